// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the CPU control sequencer.
// Holds the FSM state encoding, the instruction code field and the reset PC default.
package cpu_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC1  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_JMP  = 2'b00,
        OP_NOP  = 2'b01,
        OP_HALT = 2'b10,
        OP_ARM  = 2'b11
    } opcode_t;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    function automatic opcode_t op_of(input logic [15:0] ir);
        return opcode_t'(ir[15:14]);
    endfunction

endpackage

// File: rtl/cpu_sequencer_status_flags.sv
// CARRY and SKIP status flip-flops with independent load enables.
// Both clear asynchronously on reset.
module status_flags (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_carry_d,
    input  logic i_carry_en,
    input  logic i_skip_d,
    input  logic i_skip_en,
    output logic o_carry_q,
    output logic o_skip_q
);

    logic r_carry;
    logic r_skip;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_carry <= 1'b0;
            r_skip  <= 1'b0;
        end else begin
            if (i_carry_en) r_carry <= i_carry_d;
            if (i_skip_en)  r_skip  <= i_skip_d;
        end
    end

    assign o_carry_q = r_carry;
    assign o_skip_q  = r_skip;

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer: fetches instructions over a req/ack port, holds PC/IR and
// the instruction counter, and produces the one-cycle exec1 strobe for the ALU.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instruction,
    output logic [15:0] pc,
    output logic        exec1,
    input  logic        carryout,
    input  logic        carryen,
    input  logic        skipout,
    input  logic        skipen,
    output logic        carrystatus,
    output logic        skipstatus,
    output logic        halted,
    output logic [15:0] instr_count
);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_count;
    logic        w_exec1;
    logic        w_skip_q;
    logic        w_carry_q;
    opcode_t     w_op;

    assign w_op    = op_of(r_ir);
    assign w_exec1 = (r_state == ST_EXEC1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // JMP/HALT squash reads the SKIP value registered before this EXEC1 updates it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) w_next_state = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (w_op == OP_HALT && !w_skip_q) w_next_state = ST_HALTED;
                else if (run)                     w_next_state = ST_FETCH;
                else                              w_next_state = ST_IDLE;
            end
            ST_HALTED: begin
                if (!run) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            if (r_state == ST_FETCH && mem_ack) begin
                r_ir <= mem_rdata;
                r_pc <= r_pc + 16'd1;
            end
            if (w_exec1) begin
                r_count <= r_count + 16'd1;
                if (w_op == OP_JMP && !w_skip_q) r_pc <= {2'b00, r_ir[13:0]};
            end
        end
    end

    status_flags u_flags (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_carry_d  (carryout),
        .i_carry_en (carryen & w_exec1),
        .i_skip_d   (skipout),
        .i_skip_en  (skipen & w_exec1),
        .o_carry_q  (w_carry_q),
        .o_skip_q   (w_skip_q)
    );

    assign mem_req     = (r_state == ST_FETCH);
    assign mem_addr    = r_pc;
    assign instruction = r_ir;
    assign pc          = r_pc;
    assign exec1       = w_exec1;
    assign carrystatus = w_carry_q;
    assign skipstatus  = w_skip_q;
    assign halted      = (r_state == ST_HALTED);
    assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios then random programs,
// compared against an instruction-level reference model.
module tb_cpu_sequencer;

    localparam logic [15:0] TB_RESET_PC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic        exec1;
    logic        carryout;
    logic        carryen;
    logic        skipout;
    logic        skipen;
    logic        carrystatus;
    logic        skipstatus;
    logic        halted;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    logic [15:0] m_count;
    logic        m_carry;
    logic        m_skip;
    logic        m_halted;

    cpu_sequencer #(.RESET_PC(TB_RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .exec1       (exec1),
        .carryout    (carryout),
        .carryen     (carryen),
        .skipout     (skipout),
        .skipen      (skipen),
        .carrystatus (carrystatus),
        .skipstatus  (skipstatus),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = TB_RESET_PC;
        m_count  = '0;
        m_carry  = 1'b0;
        m_skip   = 1'b0;
        m_halted = 1'b0;
    endtask

    // One full instruction: fetch with wait states, then the execute cycle.
    task automatic do_instr(input logic [15:0] instr, input int waits,
                            input logic cin, input logic cen,
                            input logic sin, input logic sen,
                            input logic run_after, input logic drop_mid);
        logic old_skip;
        int   n;
        run = 1'b1;
        n = 0;
        while (mem_req !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk("fetch_req_seen", {15'd0, mem_req}, 16'd1);
        chk("fetch_addr", mem_addr, m_pc);
        if (drop_mid) run = 1'b0;
        for (int k = 0; k < waits; k++) begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            tick();
            chk("wait_req", {15'd0, mem_req}, 16'd1);
            chk("wait_addr", mem_addr, m_pc);
            chk("wait_exec1", {15'd0, exec1}, 16'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = instr;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        m_pc      = m_pc + 16'd1;
        chk("exec1_high", {15'd0, exec1}, 16'd1);
        chk("exec_req_low", {15'd0, mem_req}, 16'd0);
        chk("ir_loaded", instruction, instr);
        chk("pc_incr", pc, m_pc);
        carryout = cin;
        carryen  = cen;
        skipout  = sin;
        skipen   = sen;
        run      = run_after;
        tick();
        carryout = 1'b0;
        carryen  = 1'b0;
        skipout  = 1'b0;
        skipen   = 1'b0;
        old_skip = m_skip;
        m_count  = m_count + 16'd1;
        if (cen) m_carry = cin;
        if (sen) m_skip = sin;
        if (instr[15:14] == 2'b00 && !old_skip) m_pc = {2'b00, instr[13:0]};
        if (instr[15:14] == 2'b10 && !old_skip) m_halted = 1'b1;
        chk("exec1_once", {15'd0, exec1}, 16'd0);
        chk("count", instr_count, m_count);
        chk("carry", {15'd0, carrystatus}, {15'd0, m_carry});
        chk("skip", {15'd0, skipstatus}, {15'd0, m_skip});
        chk("pc_after", pc, m_pc);
        chk("halted", {15'd0, halted}, {15'd0, m_halted});
        chk("req_after", {15'd0, mem_req}, {15'd0, (!m_halted && run_after)});
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        carryout  = 1'b0;
        carryen   = 1'b0;
        skipout   = 1'b0;
        skipen    = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_pc", pc, TB_RESET_PC);
        chk("rst_ir", instruction, 16'h0000);
        chk("rst_count", instr_count, 16'h0000);
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_flags", {14'd0, carrystatus, skipstatus}, 16'd0);
        reset = 1'b0;
        tick();
        chk("idle_no_req", {15'd0, mem_req}, 16'd0);

        // Zero-wait ARM ops across the FFFF->0000 wrap; carry loads only when enabled.
        do_instr(16'hC123, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        do_instr(16'hC456, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pc_wrapped", pc, 16'h0000);

        // Async reset in the middle of a fetch.
        chk("mid_fetch_req", {15'd0, mem_req}, 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_req_drop", {15'd0, mem_req}, 16'd0);
        chk("async_pc", pc, TB_RESET_PC);
        chk("async_flags", {14'd0, carrystatus, skipstatus}, 16'd0);
        chk("async_count", instr_count, 16'h0000);
        run = 1'b0;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", {15'd0, mem_req}, 16'd0);

        do_instr(16'hC000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // FFFE
        do_instr(16'hC000, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // FFFF
        do_instr(16'hC001, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // 0000 sets SKIP
        do_instr(16'h0010, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // 0001 JMP squashed
        do_instr(16'h4000, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // 0002 NOP, 5 waits
        do_instr(16'h3FFF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // 0003 JMP 3FFF
        do_instr(16'h0004, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // 3FFF JMP 0004
        do_instr(16'h4000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); // 0004 NOP, run dips
        do_instr(16'h8000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // 0005 HALT
        tick();
        chk("halt_hold", {15'd0, halted}, 16'd1);
        chk("halt_no_req", {15'd0, mem_req}, 16'd0);
        run = 1'b0;
        tick();
        chk("unhalt", {15'd0, halted}, 16'd0);
        m_halted = 1'b0;
        run = 1'b1;
        tick();
        chk("resume_req", {15'd0, mem_req}, 16'd1);
        chk("resume_addr", mem_addr, 16'h0006);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] ins;
            if (m_halted) begin
                run = 1'b0;
                tick();
                chk("rnd_unhalt", {15'd0, halted}, 16'd0);
                m_halted = 1'b0;
            end
            ins = 16'($urandom);
            do_instr(ins, int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
